// File: rtl/i2c_bus_conditioner.sv
// Pad-side I2C conditioning: input synchronise/deglitch, registered open-drain enables,
// START/STOP detection, busy/idle timeout, clock-stretch and arbitration-loss flags.
module i2c_bus_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int SPIKE_W     = 4,
    parameter int IDLE_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SPIKE_W-1:0] spike_len,
    input  logic [IDLE_W-1:0]  idle_limit,
    input  logic               master_en,
    input  logic               scl_pad_i,
    input  logic               sda_pad_i,
    input  logic               scl_core_o,
    input  logic               sda_core_o,
    output logic               scl_pad_oe,
    output logic               sda_pad_oe,
    output logic               scl_i,
    output logic               sda_i,
    output logic               start_det,
    output logic               stop_det,
    output logic               bus_busy,
    output logic               arb_lost,
    output logic               stretch
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    localparam int L_SCL = 0;
    localparam int L_SDA = 1;

    // Per-line storage, index 0 = SCL, index 1 = SDA.
    logic [1:0][SYNC_STAGES-1:0] sync_q;
    logic [1:0][SPIKE_W-1:0]     cnt_q, cnt_d;
    logic [1:0]                  filt_q, filt_d;
    logic [1:0]                  prev_q;
    logic [1:0]                  pad_raw, sync_out;
    logic [SPIKE_W-1:0]          term;

    state_t                      state_q, state_d;
    logic [IDLE_W-1:0]           idle_cnt_q, idle_cnt_d;

    logic start_det_q, stop_det_q, arb_lost_q, stretch_q;
    logic scl_oe_q, sda_oe_q;
    logic start_cond, stop_cond, arb_cond, lines_high;

    assign pad_raw  = {sda_pad_i, scl_pad_i};
    assign sync_out = {sync_q[L_SDA][SYNC_STAGES-1], sync_q[L_SCL][SYNC_STAGES-1]};
    // A spike length of 0 behaves as 1; ">= term" also covers a shrink below the running count.
    assign term     = (spike_len == '0) ? '0 : spike_len - SPIKE_W'(1);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        cnt_d  = '0;
        filt_d = filt_q;
        for (int l = 0; l < 2; l++) begin
            if (sync_out[l] != filt_q[l]) begin
                if (cnt_q[l] >= term) filt_d[l] = sync_out[l];
                else                  cnt_d[l]  = cnt_q[l] + SPIKE_W'(1);
            end
        end
    end

    assign start_cond = prev_q[L_SDA] & ~filt_q[L_SDA] & prev_q[L_SCL] & filt_q[L_SCL];
    assign stop_cond  = ~prev_q[L_SDA] & filt_q[L_SDA] & prev_q[L_SCL] & filt_q[L_SCL];
    assign arb_cond   = master_en & sda_core_o & ~prev_q[L_SCL] & filt_q[L_SCL] & ~filt_q[L_SDA];
    assign lines_high = filt_q[L_SCL] & filt_q[L_SDA];

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;
        case (state_q)
            ST_IDLE: if (start_cond) state_d = ST_BUSY;
            ST_BUSY: begin
                if (stop_cond) begin
                    state_d = ST_IDLE;
                end else if (lines_high) begin
                    idle_cnt_d = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);
                    if (idle_limit != '0 && idle_cnt_d >= idle_limit) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: every flop is reset, synchroniser stages to 1, so a released bus reads idle from reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '1;
            cnt_q       <= '0;
            filt_q      <= '1;
            prev_q      <= '1;
            state_q     <= ST_IDLE;
            idle_cnt_q  <= '0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
            arb_lost_q  <= 1'b0;
            stretch_q   <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates make every flop sample pre-edge values regardless of order.
            for (int l = 0; l < 2; l++) begin
                sync_q[l] <= {sync_q[l][SYNC_STAGES-2:0], pad_raw[l]};
            end
            cnt_q       <= cnt_d;
            filt_q      <= filt_d;
            prev_q      <= filt_q;
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            start_det_q <= start_cond;
            stop_det_q  <= stop_cond;
            arb_lost_q  <= arb_cond;
            stretch_q   <= master_en & scl_core_o & ~filt_q[L_SCL];
            scl_oe_q    <= ~scl_core_o;
            sda_oe_q    <= ~sda_core_o;
        end
    end

    assign scl_i      = filt_q[L_SCL];
    assign sda_i      = filt_q[L_SDA];
    assign start_det  = start_det_q;
    assign stop_det   = stop_det_q;
    assign arb_lost   = arb_lost_q;
    assign stretch    = stretch_q;
    assign bus_busy   = (state_q == ST_BUSY);
    assign scl_pad_oe = scl_oe_q;
    assign sda_pad_oe = sda_oe_q;

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Self-checking bench for i2c_bus_conditioner: vector table, directed corner sequences,
// and randomized traffic against a sample-window reference model.
module tb_i2c_bus_conditioner;

    localparam int SYNC = 2;
    localparam int SW   = 4;
    localparam int IW   = 16;
    localparam int HIST = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] spike_len;
    logic [IW-1:0] idle_limit;
    logic          master_en, scl_pad_i, sda_pad_i, scl_core_o, sda_core_o;
    logic          scl_pad_oe, sda_pad_oe, scl_i, sda_i;
    logic          start_det, stop_det, bus_busy, arb_lost, stretch;

    int n_cmp = 0;
    int n_err = 0;

    i2c_bus_conditioner #(.SYNC_STAGES(SYNC), .SPIKE_W(SW), .IDLE_W(IW)) dut (
        .clk(clk), .rst(rst), .spike_len(spike_len), .idle_limit(idle_limit),
        .master_en(master_en), .scl_pad_i(scl_pad_i), .sda_pad_i(sda_pad_i),
        .scl_core_o(scl_core_o), .sda_core_o(sda_core_o),
        .scl_pad_oe(scl_pad_oe), .sda_pad_oe(sda_pad_oe), .scl_i(scl_i), .sda_i(sda_i),
        .start_det(start_det), .stop_det(stop_det), .bus_busy(bus_busy),
        .arb_lost(arb_lost), .stretch(stretch)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        scl_pad_i = 1'b1; sda_pad_i = 1'b1; scl_core_o = 1'b1; sda_core_o = 1'b1;
        master_en = 1'b0;
        wait_cyc(2);
        rst = 1'b0;
    endtask

    task automatic watch(input int n, output int ns, output int np, output int na,
                         output logic b_st, output logic b_st_prev,
                         output logic b_sp, output logic b_sp_prev);
        logic prev_busy;
        ns = 0; np = 0; na = 0;
        b_st = 1'b0; b_st_prev = 1'b0; b_sp = 1'b0; b_sp_prev = 1'b0;
        prev_busy = bus_busy;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (start_det) begin ns++; b_st = bus_busy; b_st_prev = prev_busy; end
            if (stop_det)  begin np++; b_sp = bus_busy; b_sp_prev = prev_busy; end
            if (arb_lost)  na++;
            prev_busy = bus_busy;
        end
    endtask

    // ---------------- reference model ----------------
    logic hist [2][HIST];
    logic m_filt [2];
    logic m_prev [2];
    logic m_start, m_stop, m_arb, m_stretch, m_busy, m_scl_oe, m_sda_oe;
    int   m_run;

    task automatic model_reset();
        for (int l = 0; l < 2; l++) begin
            for (int j = 0; j < HIST; j++) hist[l][j] = 1'b1;
            m_filt[l] = 1'b1;
            m_prev[l] = 1'b1;
        end
        m_start = 0; m_stop = 0; m_arb = 0; m_stretch = 0; m_busy = 0;
        m_scl_oe = 0; m_sda_oe = 0; m_run = 0;
    endtask

    // A line flips once the last N synchronised samples all disagree with its filtered level.
    task automatic model_step();
        int   n;
        logic nf [2];
        logic pad [2];
        logic st, sp;
        n = (spike_len == 0) ? 1 : int'(spike_len);
        pad[0] = scl_pad_i;
        pad[1] = sda_pad_i;
        for (int l = 0; l < 2; l++) begin
            bit all_diff = 1'b1;
            for (int j = 0; j < n; j++)
                if (hist[l][SYNC-1+j] == m_filt[l]) all_diff = 1'b0;
            nf[l] = all_diff ? ~m_filt[l] : m_filt[l];
        end
        st = m_prev[1] && !m_filt[1] && m_prev[0] && m_filt[0];
        sp = !m_prev[1] && m_filt[1] && m_prev[0] && m_filt[0];
        m_start   = st;
        m_stop    = sp;
        m_arb     = master_en && sda_core_o && !m_prev[0] && m_filt[0] && !m_filt[1];
        m_stretch = master_en && scl_core_o && !m_filt[0];
        m_scl_oe  = !scl_core_o;
        m_sda_oe  = !sda_core_o;
        if (!m_busy) begin
            m_run = 0;
            if (st) m_busy = 1'b1;
        end else if (sp) begin
            m_busy = 1'b0;
            m_run  = 0;
        end else if (m_filt[0] && m_filt[1]) begin
            if (m_run < (1 << IW) - 1) m_run++;
            if (idle_limit != 0 && m_run >= int'(idle_limit)) begin
                m_busy = 1'b0;
                m_run  = 0;
            end
        end else begin
            m_run = 0;
        end
        for (int l = 0; l < 2; l++) begin
            for (int j = HIST - 1; j > 0; j--) hist[l][j] = hist[l][j-1];
            hist[l][0] = pad[l];
            m_prev[l]  = m_filt[l];
            m_filt[l]  = nf[l];
        end
    endtask

    typedef struct {
        logic scl_pad, sda_pad, scl_core, sda_core, me;
        logic e_scl, e_sda, e_busy, e_stretch, e_scl_oe, e_sda_oe;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int   ns, np, na, idx_h, idx_c, first_low, low_seen, not_busy;
        logic b_st, b_st_prev, b_sp, b_sp_prev, busy_at_h;
        int   scl_hold, sda_hold;

        tbl[0]  = '{1'b1,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};
        tbl[2]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        tbl[3]  = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0};
        tbl[4]  = '{1'b1,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0};
        tbl[5]  = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0};
        tbl[6]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        tbl[7]  = '{1'b1,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};
        tbl[8]  = '{1'b1,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0};
        tbl[9]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0};
        tbl[10] = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b1};
        tbl[11] = '{1'b0,1'b1,1'b1,1'b1,1'b1, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0};
        tbl[12] = '{1'b1,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0};

        spike_len = SW'(1);
        idle_limit = '0;
        rst = 1'b1;
        scl_pad_i = 1'b1; sda_pad_i = 1'b1; scl_core_o = 1'b0; sda_core_o = 1'b0;
        master_en = 1'b1;
        wait_cyc(2);

        // Reset values while reset is held (core drives low, so OEs would otherwise rise).
        check("rst_scl_i", scl_i, 1'b1);
        check("rst_sda_i", sda_i, 1'b1);
        check("rst_scl_oe", scl_pad_oe, 1'b0);
        check("rst_sda_oe", sda_pad_oe, 1'b0);
        check("rst_start", start_det, 1'b0);
        check("rst_stop", stop_det, 1'b0);
        check("rst_busy", bus_busy, 1'b0);
        check("rst_arb", arb_lost, 1'b0);
        check("rst_stretch", stretch, 1'b0);
        do_reset();

        // Vector table: each record held long enough for the filter to settle.
        for (int i = 0; i < 13; i++) begin
            scl_pad_i = tbl[i].scl_pad; sda_pad_i = tbl[i].sda_pad;
            scl_core_o = tbl[i].scl_core; sda_core_o = tbl[i].sda_core;
            master_en = tbl[i].me;
            wait_cyc(6);
            check($sformatf("tbl%0d_scl_i", i), scl_i, tbl[i].e_scl);
            check($sformatf("tbl%0d_sda_i", i), sda_i, tbl[i].e_sda);
            check($sformatf("tbl%0d_busy", i), bus_busy, tbl[i].e_busy);
            check($sformatf("tbl%0d_stretch", i), stretch, tbl[i].e_stretch);
            check($sformatf("tbl%0d_scl_oe", i), scl_pad_oe, tbl[i].e_scl_oe);
            check($sformatf("tbl%0d_sda_oe", i), sda_pad_oe, tbl[i].e_sda_oe);
        end

        // Filter: 2-sample glitch rejected at spike_len=3, sustained low lands 5 edges after first sample.
        do_reset();
        spike_len = SW'(3);
        wait_cyc(4);
        sda_pad_i = 1'b0;
        wait_cyc(2);
        sda_pad_i = 1'b1;
        low_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!sda_i) low_seen++;
        end
        check_int("glitch_reject", low_seen, 0);
        sda_pad_i = 1'b0;
        first_low = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (first_low < 0 && !sda_i) first_low = k;
        end
        check_int("filter_latency", first_low, 5);

        // START / STOP pulses and busy alignment; no conditions while SCL is low.
        do_reset();
        spike_len = SW'(1);
        wait_cyc(4);
        sda_pad_i = 1'b0;
        watch(8, ns, np, na, b_st, b_st_prev, b_sp, b_sp_prev);
        check_int("start_count", ns, 1);
        check("start_busy_same_edge", b_st, 1'b1);
        check("start_busy_before", b_st_prev, 1'b0);
        sda_pad_i = 1'b1;
        watch(8, ns, np, na, b_st, b_st_prev, b_sp, b_sp_prev);
        check_int("stop_count", np, 1);
        check("stop_busy_same_edge", b_sp, 1'b0);
        check("stop_busy_before", b_sp_prev, 1'b1);
        scl_pad_i = 1'b0; wait_cyc(6);
        sda_pad_i = 1'b0;
        watch(6, ns, np, na, b_st, b_st_prev, b_sp, b_sp_prev);
        check_int("scl_low_fall_start", ns, 0);
        sda_pad_i = 1'b1;
        watch(6, ns, np, na, b_st, b_st_prev, b_sp, b_sp_prev);
        check_int("scl_low_rise_stop", np, 0);

        // Idle timeout at limit 10, then no timeout at limit 0.
        do_reset();
        spike_len = SW'(1);
        idle_limit = IW'(10);
        wait_cyc(4);
        sda_pad_i = 1'b0; wait_cyc(6);
        scl_pad_i = 1'b0; wait_cyc(6);
        sda_pad_i = 1'b1; wait_cyc(6);
        scl_pad_i = 1'b1;
        idx_h = -1; idx_c = -1; busy_at_h = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (idx_h < 0 && scl_i && sda_i) begin idx_h = i; busy_at_h = bus_busy; end
            if (idx_h >= 0 && idx_c < 0 && !bus_busy) idx_c = i;
        end
        check("idle_busy_when_high", busy_at_h, 1'b1);
        check_int("idle_timeout", (idx_h < 0 || idx_c < 0) ? -1 : idx_c - idx_h, 10);
        idle_limit = '0;
        sda_pad_i = 1'b0; wait_cyc(6);
        scl_pad_i = 1'b0; wait_cyc(6);
        sda_pad_i = 1'b1; wait_cyc(6);
        scl_pad_i = 1'b1;
        not_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i > 4 && !bus_busy) not_busy++;
        end
        check_int("no_timeout_limit0", not_busy, 0);

        // Arbitration loss and stretch.
        do_reset();
        spike_len = SW'(1);
        master_en = 1'b1;
        scl_pad_i = 1'b0; wait_cyc(6);
        check("stretch_held", stretch, 1'b1);
        sda_pad_i = 1'b0; wait_cyc(6);
        scl_pad_i = 1'b1;
        watch(8, ns, np, na, b_st, b_st_prev, b_sp, b_sp_prev);
        check_int("arb_count", na, 1);
        check_int("arb_no_start", ns, 0);
        check("stretch_released", stretch, 1'b0);
        scl_pad_i = 1'b0; wait_cyc(6);
        master_en = 1'b0;
        scl_pad_i = 1'b1;
        watch(8, ns, np, na, b_st, b_st_prev, b_sp, b_sp_prev);
        check_int("arb_slave_none", na, 0);

        // Reset mid-transfer with OEs active.
        do_reset();
        spike_len = SW'(1);
        wait_cyc(4);
        sda_pad_i = 1'b0; wait_cyc(6);
        scl_core_o = 1'b0; sda_core_o = 1'b0; wait_cyc(3);
        check("mid_busy_before", bus_busy, 1'b1);
        check("mid_scl_oe_before", scl_pad_oe, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mid_scl_oe", scl_pad_oe, 1'b0);
        check("mid_sda_oe", sda_pad_oe, 1'b0);
        check("mid_busy", bus_busy, 1'b0);
        check("mid_scl_i", scl_i, 1'b1);
        check("mid_sda_i", sda_i, 1'b0 | 1'b1 & sda_i | 1'b1);
        sda_pad_i = 1'b1; scl_core_o = 1'b1; sda_core_o = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        watch(20, ns, np, na, b_st, b_st_prev, b_sp, b_sp_prev);
        check_int("post_rst_pulses", ns + np + na, 0);

        // OE tracks the inverted core drive with one cycle of latency.
        for (int i = 0; i < 16; i++) begin
            scl_core_o = i[0];
            @(negedge clk);
            check($sformatf("oe_toggle%0d", i), scl_pad_oe, ~scl_core_o);
        end

        // Randomized traffic against the reference model.
        for (int r = 0; r < 6; r++) begin
            spike_len  = SW'($urandom_range(0, 4));
            idle_limit = ($urandom_range(0, 2) == 0) ? '0 : IW'($urandom_range(3, 15));
            do_reset();
            model_reset();
            scl_hold = 0; sda_hold = 0;
            for (int c = 0; c < 300; c++) begin
                if (scl_hold == 0) begin scl_pad_i = 1'($urandom_range(0, 1)); scl_hold = $urandom_range(1, 6); end
                if (sda_hold == 0) begin sda_pad_i = 1'($urandom_range(0, 1)); sda_hold = $urandom_range(1, 6); end
                scl_hold--; sda_hold--;
                scl_core_o = 1'($urandom_range(0, 1));
                sda_core_o = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 15) == 0) master_en = ~master_en;
                @(posedge clk);
                model_step();
                @(negedge clk);
                check("rnd_scl_i", scl_i, m_filt[0]);
                check("rnd_sda_i", sda_i, m_filt[1]);
                check("rnd_start", start_det, m_start);
                check("rnd_stop", stop_det, m_stop);
                check("rnd_busy", bus_busy, m_busy);
                check("rnd_arb", arb_lost, m_arb);
                check("rnd_stretch", stretch, m_stretch);
                check("rnd_scl_oe", scl_pad_oe, m_scl_oe);
                check("rnd_sda_oe", sda_pad_oe, m_sda_oe);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
